// File: rtl/bar_pkg.sv
// Screen geometry and bar motion direction encoding.
// Shared by bar_motion, draw_bar and vga_controller.
package bar_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        LEFT  = 2'b01,
        RIGHT = 2'b10
    } dir_t;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchroniser followed by a counter-based debouncer for one active-low button.
// Latency: 2 sync cycles + DEBOUNCE_CYCLES stable cycles; any bounce restarts the count.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 270000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_n,
    output logic deb_n
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          deb_q, deb_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d = btn_n;
        sync2_d = sync1_q;
        deb_d   = deb_q;
        cnt_d   = '0;
        // Counter only runs while the synchronised level disagrees with the debounced one.
        if (sync2_q != deb_q) begin
            if (cnt_q == CNT_LAST) begin
                deb_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            deb_q   <= 1'b1;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
        end
    end

    assign deb_n = deb_q;

endmodule

// File: rtl/bar_motion.sv
// Bar x position: debounced buttons steer a once-per-frame move on the VS falling edge, clamped to screen.
// Outputs update 1 cycle after VS is first sampled low; BAR_ACCEL_EN adds a per-frame step ramp.
module bar_motion #(
    parameter int SCREEN_W        = bar_pkg::SCREEN_W,
    parameter int BAR_W           = 64,
    parameter int X_RESET         = 288,
    parameter int SPEED           = 4,
    parameter int MAX_SPEED       = 12,
    parameter int DEBOUNCE_CYCLES = 270000
) (
    input  logic       iCLK_27MHz,
    input  logic       ireset,
    input  logic       iVGA_VS,
    input  logic       ibtn_left_n,
    input  logic       ibtn_right_n,
    output logic [9:0] obar_x,
    output logic [1:0] odir,
    output logic       oframe_tick
);
    import bar_pkg::*;

    localparam logic signed [10:0] X_MAX   = 11'(SCREEN_W - BAR_W);
    localparam logic        [9:0]  X_INIT  = 10'(X_RESET);
    localparam logic        [9:0]  STEP0   = 10'(SPEED);

    logic left_n, right_n;
    logic left_p, right_p;
    logic tick;

    logic       vs_q, vs_d;
    dir_t       dir_q, dir_d, nxt_dir;
    logic [9:0] bar_x_q, bar_x_d;
    logic       frame_tick_q, frame_tick_d;
    logic [9:0] step;
    logic signed [10:0] x_ext, step_ext, sum, diff;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_left (
        .clk   (iCLK_27MHz),
        .reset (ireset),
        .btn_n (ibtn_left_n),
        .deb_n (left_n)
    );

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_right (
        .clk   (iCLK_27MHz),
        .reset (ireset),
        .btn_n (ibtn_right_n),
        .deb_n (right_n)
    );

    assign left_p  = ~left_n;
    assign right_p = ~right_n;

`ifdef BAR_ACCEL_EN
    localparam logic [9:0] STEP_MAX = 10'(MAX_SPEED);
    logic [9:0] step_q, step_d;

    assign step = step_q;

    // The ramp applies from the next tick; this tick still moves by step_q.
    always_comb begin
        step_d = step_q;
        if (tick) begin
            if (nxt_dir == dir_q && nxt_dir != IDLE) begin
                step_d = (step_q >= STEP_MAX) ? STEP_MAX : step_q + 10'd1;
            end else begin
                step_d = STEP0;
            end
        end
    end

    always_ff @(posedge iCLK_27MHz) begin
        if (ireset) begin
            step_q <= STEP0;
        end else begin
            step_q <= step_d;
        end
    end
`else
    assign step = STEP0;
`endif

    always_comb begin
        vs_d = iVGA_VS;
        tick = vs_q & ~iVGA_VS;

        nxt_dir = IDLE;
        if (left_p && !right_p) begin
            nxt_dir = LEFT;
        end else if (right_p && !left_p) begin
            nxt_dir = RIGHT;
        end

        // 11-bit signed so a left move below zero is caught instead of wrapping.
        x_ext    = {1'b0, bar_x_q};
        step_ext = {1'b0, step};
        sum      = x_ext + step_ext;
        diff     = x_ext - step_ext;

        bar_x_d      = bar_x_q;
        dir_d        = dir_q;
        frame_tick_d = tick;
        if (tick) begin
            dir_d = nxt_dir;
            case (nxt_dir)
                LEFT:    bar_x_d = (diff < 0) ? 10'd0 : diff[9:0];
                RIGHT:   bar_x_d = (sum > X_MAX) ? X_MAX[9:0] : sum[9:0];
                default: bar_x_d = bar_x_q;
            endcase
        end
    end

    always_ff @(posedge iCLK_27MHz) begin
        if (ireset) begin
            vs_q         <= 1'b1;
            dir_q        <= IDLE;
            bar_x_q      <= X_INIT;
            frame_tick_q <= 1'b0;
        end else begin
            vs_q         <= vs_d;
            dir_q        <= dir_d;
            bar_x_q      <= bar_x_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign obar_x      = bar_x_q;
    assign odir        = dir_q;
    assign oframe_tick = frame_tick_q;

endmodule

// File: tb/tb_bar_motion.sv
// Bench for bar_motion: vector table of held-button frame runs plus bounce and mid-frame reset sequences.
// Expected positions are pushed to a scoreboard at each VS falling edge and popped on oframe_tick.
module tb_bar_motion;

    logic       clk = 1'b0;
    logic       rst;
    logic       vs;
    logic       bl_n;
    logic       br_n;
    logic [9:0] bar_x;
    logic [1:0] dir;
    logic       ftick;

    always #5 clk = ~clk;

    bar_motion #(.DEBOUNCE_CYCLES(4)) dut (
        .iCLK_27MHz   (clk),
        .ireset       (rst),
        .iVGA_VS      (vs),
        .ibtn_left_n  (bl_n),
        .ibtn_right_n (br_n),
        .obar_x       (bar_x),
        .odir         (dir),
        .oframe_tick  (ftick)
    );

    typedef struct {
        int x;
        int d;
    } exp_t;

    typedef struct {
        logic l_n;
        logic r_n;
        int   frames;
        int   x;
        int   d;
    } vec_t;

    exp_t sb[$];
    vec_t tv[7];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   m_x;
    int   m_d;
    int   prev_x;
    bit   mon_en = 1'b0;

    task automatic chk(input string name, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Reference model of one tick, using the button levels currently held.
    task automatic model_push();
        exp_t e;
        if (!bl_n && br_n) begin
            m_d = 1;
            m_x = (m_x - 4 < 0) ? 0 : m_x - 4;
        end else if (!br_n && bl_n) begin
            m_d = 2;
            m_x = (m_x + 4 > 576) ? 576 : m_x + 4;
        end else begin
            m_d = 0;
        end
        e.x = m_x;
        e.d = m_d;
        sb.push_back(e);
    endtask

    task automatic vs_pulse();
        vs = 1'b0;
        cyc(2);
        vs = 1'b1;
    endtask

    task automatic frame();
        cyc(98);
        model_push();
        vs_pulse();
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (ftick) begin
                if (sb.size() == 0) begin
                    chk("unexpected_tick", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("tick_x", int'(bar_x), e.x);
                    chk("tick_dir", int'(dir), e.d);
                end
            end else begin
                chk("hold_x", int'(bar_x), prev_x);
            end
            prev_x = int'(bar_x);
        end
    end

    initial begin
        tv[0] = '{1'b1, 1'b1,   5, 288, 0};
        tv[1] = '{1'b1, 1'b0,   2, 296, 2};
        tv[2] = '{1'b0, 1'b1,  76,   0, 1};
        tv[3] = '{1'b0, 1'b0,   3,   0, 0};
        tv[4] = '{1'b1, 1'b0, 150, 576, 2};
        tv[5] = '{1'b1, 1'b1,   2, 576, 0};
        tv[6] = '{1'b0, 1'b1,   3, 564, 1};

        rst  = 1'b1;
        vs   = 1'b1;
        bl_n = 1'b1;
        br_n = 1'b1;
        cyc(3);
        chk("reset_x", int'(bar_x), 288);
        chk("reset_dir", int'(dir), 0);
        chk("reset_tick", int'(ftick), 0);
        rst    = 1'b0;
        m_x    = 288;
        m_d    = 0;
        prev_x = 288;
        mon_en = 1'b1;

        for (int i = 0; i < 7; i++) begin
            bl_n = tv[i].l_n;
            br_n = tv[i].r_n;
            repeat (tv[i].frames) frame();
            cyc(1);
            chk($sformatf("row%0d_x", i), int'(bar_x), tv[i].x);
            chk($sformatf("row%0d_dir", i), int'(dir), tv[i].d);
        end

        // Bounce on the left button right up to the VS edge must never register.
        bl_n = 1'b1;
        br_n = 1'b1;
        frame();
        cyc(58);
        for (int k = 0; k < 20; k++) begin
            bl_n = ~bl_n;
            cyc(2);
        end
        model_push();
        vs_pulse();
        cyc(1);
        chk("bounce_x", int'(bar_x), 564);
        chk("bounce_dir", int'(dir), 0);

        // Reset lands on the tick cycle with right held; that tick must be dropped.
        br_n = 1'b0;
        frame();
        cyc(98);
        vs     = 1'b0;
        rst    = 1'b1;
        mon_en = 1'b0;
        cyc(1);
        chk("midrst_x", int'(bar_x), 288);
        chk("midrst_dir", int'(dir), 0);
        chk("midrst_tick", int'(ftick), 0);
        cyc(1);
        vs     = 1'b1;
        rst    = 1'b0;
        m_x    = 288;
        m_d    = 0;
        prev_x = 288;
        sb.delete();
        mon_en = 1'b1;
        frame();
        cyc(1);
        chk("post_rst_x", int'(bar_x), 292);
        chk("post_rst_dir", int'(dir), 2);

        cyc(5);
        chk("sb_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
